// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Multi-domain reset generator for the FPGA top level, between the PLL and the
//   SoC. Three reset sources are merged:
//     - PORESETn   : PLL-lock / board power-on reset. Asserts asynchronously,
//                    deasserts through a SYNC_STAGES-deep synchroniser.
//     - BTN_RST    : raw, bouncy pushbutton. Synchronised, then debounced.
//     - SW_RST_REQ : synchronous software request (level or 1-cycle pulse).
//   All NUM_OUT outputs assert together. They release in order RSTn_O[0],
//   RSTn_O[1], ... after a HOLD_CYCLES hold, STAGE_GAP cycles apart.
//
// Ports
//   CLK         in   single clock
//   PORESETn    in   async active-low master reset
//   BTN_RST     in   raw pushbutton, active high, asynchronous
//   SW_RST_REQ  in   synchronous software reset request
//   RSTn_O      out  [NUM_OUT] staged active-low resets, registered
//   BUSY        out  high whenever the sequencer is not in RUN
//   RST_CAUSE   out  [3] one-hot {SW,BTN,POR} cause of the last reset
//                    (present only with RESET_SEQ_CAUSE_EN defined)
//
// Optional feature macro: RESET_SEQ_CAUSE_EN (adds RST_CAUSE and its register).
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_OUT         = 3,
  parameter int HOLD_CYCLES     = 255,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               CLK,
  input  logic               PORESETn,
  input  logic               BTN_RST,
  input  logic               SW_RST_REQ,
  output logic [NUM_OUT-1:0] RSTn_O,
  output logic               BUSY
`ifdef RESET_SEQ_CAUSE_EN
  ,
  output logic [2:0]         RST_CAUSE
`endif
);

  // Counters count 0..MAX-1 and are compared for equality, never wrapped.
  localparam int HW = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int GW = (STAGE_GAP > 1)       ? $clog2(STAGE_GAP)       : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST  = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [DW-1:0] DB_LAST   = DW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  // With no stage gap every output goes at once; with a single output the
  // first release is also the last.
  localparam bit               FIRST_DONE = (STAGE_GAP == 0) || (NUM_OUT == 1);
  localparam logic [NUM_OUT-1:0] FIRST_RSTN =
    (STAGE_GAP == 0) ? {NUM_OUT{1'b1}} : NUM_OUT'(1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. Both chains are cleared by PORESETn so the button reads as
  // released while the master reset is active.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] por_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   rst_sync;
  logic                   btn_s;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      por_sync <= '0;
      btn_sync <= '0;
    end else begin
      por_sync <= {por_sync[SYNC_STAGES-2:0], 1'b1};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], BTN_RST};
    end
  end

  assign rst_sync = por_sync[SYNC_STAGES-1];
  assign btn_s    = btn_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: btn_db follows btn_s only after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles; any agreeing cycle restarts the count.
  // ---------------------------------------------------------------------------
  logic          btn_db;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t             state;
  logic [NUM_OUT-1:0] rstn_q;
  logic               busy_q;
  logic [HW-1:0]      hold_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               req;
  logic               fire0;
  logic [NUM_OUT-1:0] rstn_step;

  assign req = btn_db | SW_RST_REQ;

  // Released outputs always form a thermometer code from bit 0 upward, so the
  // next stage is produced by OR-ing in a left shift; the stage index k is the
  // number of ones in rstn_q.
  assign rstn_step = rstn_q | (rstn_q << 1);

  // Release of RSTn_O[0]: end of HOLD, or straight out of ASSERT when there is
  // no hold period at all.
  assign fire0 = !req &&
                 (((state == ST_ASSERT) && rst_sync && (HOLD_CYCLES == 0)) ||
                  ((state == ST_HOLD) && (hold_cnt == HOLD_LAST)));

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state    <= ST_ASSERT;
      rstn_q   <= '0;
      busy_q   <= 1'b1;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        ST_ASSERT: begin
          if (rst_sync && !req) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!req) hold_cnt <= hold_cnt + 1'b1;
        end
        ST_RELEASE: begin
          if (!req) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              rstn_q  <= rstn_step;
              if (&rstn_step) begin
                state  <= ST_RUN;
                busy_q <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        ST_RUN: ;
      endcase

      if (fire0) begin
        rstn_q   <= FIRST_RSTN;
        hold_cnt <= '0;
        gap_cnt  <= '0;
        state    <= FIRST_DONE ? ST_RUN : ST_RELEASE;
        busy_q   <= !FIRST_DONE;
      end

      // A request in any state restarts the whole sequence; a partially
      // released set of outputs is pulled low again on the same edge.
      if (req) begin
        state    <= ST_ASSERT;
        rstn_q   <= '0;
        busy_q   <= 1'b1;
        hold_cnt <= '0;
        gap_cnt  <= '0;
      end
    end
  end

  assign RSTn_O = rstn_q;
  assign BUSY   = busy_q;

`ifdef RESET_SEQ_CAUSE_EN
  // Cause is captured only on entry to ASSERT, so a request held across
  // several cycles (or a second source joining in) does not overwrite it.
  logic [2:0] cause_q;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      cause_q <= 3'b001;
    end else if (req && (state != ST_ASSERT)) begin
      cause_q <= btn_db ? 3'b010 : 3'b100;
    end
  end

  assign RST_CAUSE = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer. Two instances share stimulus: u_dut with
//   default parameters and u_fast with HOLD_CYCLES=0, STAGE_GAP=0, NUM_OUT=4.
//   Expected output snapshots are queued with the edge at which they must hold
//   and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       PORESETn;
  logic       BTN_RST;
  logic       SW_RST_REQ;
  logic [2:0] rstn_d;
  logic       busy_d;
  logic [3:0] rstn_f;
  logic       busy_f;
`ifdef RESET_SEQ_CAUSE_EN
  logic [2:0] cause_d;
  logic [2:0] cause_f;
`endif

  always #5 CLK = ~CLK;

  reset_sequencer u_dut (
    .CLK        (CLK),
    .PORESETn   (PORESETn),
    .BTN_RST    (BTN_RST),
    .SW_RST_REQ (SW_RST_REQ),
    .RSTn_O     (rstn_d),
    .BUSY       (busy_d)
`ifdef RESET_SEQ_CAUSE_EN
    ,
    .RST_CAUSE  (cause_d)
`endif
  );

  reset_sequencer #(
    .NUM_OUT     (4),
    .HOLD_CYCLES (0),
    .STAGE_GAP   (0)
  ) u_fast (
    .CLK        (CLK),
    .PORESETn   (PORESETn),
    .BTN_RST    (BTN_RST),
    .SW_RST_REQ (SW_RST_REQ),
    .RSTn_O     (rstn_f),
    .BUSY       (busy_f)
`ifdef RESET_SEQ_CAUSE_EN
    ,
    .RST_CAUSE  (cause_f)
`endif
  );

  // which: 0 = default {BUSY,RSTn_O}, 1 = fast {BUSY,RSTn_O}, 2 = RST_CAUSE
  typedef struct {
    string      tag;
    int         at;
    int         which;
    logic [7:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  ncmp  = 0;
  int  nfail = 0;
  int  cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] dv(logic b, logic [2:0] r);
    return {4'b0, b, r};
  endfunction

  function automatic logic [7:0] fv(logic b, logic [3:0] r);
    return {3'b0, b, r};
  endfunction

  function automatic logic [7:0] observe(int which);
    case (which)
      0:       return {4'b0, busy_d, rstn_d};
      1:       return {3'b0, busy_f, rstn_f};
`ifdef RESET_SEQ_CAUSE_EN
      default: return {5'b0, cause_d};
`else
      default: return 8'h00;
`endif
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge E counts from the first rising edge after the stimulus change made at
  // cycle count 'base'; that edge is sampled when cyc == base+1+E.
  task automatic push(string tag, int base, int e, int which, logic [7:0] exp);
    sb_t s;
    s.tag = tag; s.at = base + 1 + e; s.which = which; s.exp = exp;
    sbq.push_back(s);
  endtask

  task automatic push_cause(string tag, int base, int e, logic [2:0] c);
`ifdef RESET_SEQ_CAUSE_EN
    push(tag, base, e, 2, {5'b0, c});
`endif
  endtask

  task automatic drain(string tag, int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    #1;
    check({tag, "_timeout"}, 8'(sbq.size()), 8'd0);
    sbq.delete();
  endtask

  always @(negedge CLK) begin
    sb_t e;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      check(e.tag, observe(e.which), e.exp);
    end
  end

  initial begin
    int base;
    PORESETn   = 1'b0;
    BTN_RST    = 1'b0;
    SW_RST_REQ = 1'b0;
    repeat (5) @(negedge CLK);

    // Reset state
    check("rst_dflt", observe(0), dv(1'b1, 3'b000));
    check("rst_fast", observe(1), fv(1'b1, 4'b0000));
`ifdef RESET_SEQ_CAUSE_EN
    check("rst_cause", observe(2), 8'h01);
`endif

    // Power-on release: staged at 257/273/289; fast instance all at edge 2
    PORESETn = 1'b1;
    base = cyc;
    push("t6_fast_e1",  base, 1,   1, fv(1'b1, 4'b0000));
    push("t6_fast_e2",  base, 2,   1, fv(1'b0, 4'b1111));
    push("t1_e256",     base, 256, 0, dv(1'b1, 3'b000));
    push("t1_e257",     base, 257, 0, dv(1'b1, 3'b001));
    push("t1_e272",     base, 272, 0, dv(1'b1, 3'b001));
    push("t1_e273",     base, 273, 0, dv(1'b1, 3'b011));
    push("t1_e288",     base, 288, 0, dv(1'b1, 3'b011));
    push("t1_e289",     base, 289, 0, dv(1'b0, 3'b111));
    push_cause("t1_cause", base, 289, 3'b001);
    drain("t1", 400);

    // Button glitches shorter than the debounce window are ignored
    for (int g = 0; g < 3; g++) begin
      BTN_RST = 1'b1;
      repeat (100) @(negedge CLK);
      BTN_RST = 1'b0;
      repeat (100) @(negedge CLK);
    end
    base = cyc;
    push("t2_glitch0",  base, 0,  0, dv(1'b0, 3'b111));
    push("t2_glitch50", base, 50, 0, dv(1'b0, 3'b111));
    drain("t2g", 100);

    // Held press: RSTn_O low at edge 1002 (1003rd edge after press)
    BTN_RST = 1'b1;
    base = cyc;
    push("t2_e1001", base, 1001, 0, dv(1'b0, 3'b111));
    push("t2_e1002", base, 1002, 0, dv(1'b1, 3'b000));
    push_cause("t2_cause", base, 1002, 3'b010);
    push("t2_e1500", base, 1500, 0, dv(1'b1, 3'b000));
    repeat (2000) @(negedge CLK);
    BTN_RST = 1'b0;
    base = cyc;
    push("t2r_e1256", base, 1256, 0, dv(1'b1, 3'b000));
    push("t2r_e1257", base, 1257, 0, dv(1'b1, 3'b001));
    push("t2r_e1289", base, 1289, 0, dv(1'b0, 3'b111));
    push_cause("t2r_cause", base, 1289, 3'b010);
    drain("t2", 1400);

    // One-cycle SW pulse in RUN
    SW_RST_REQ = 1'b1;
    base = cyc;
    push("t3_e0",   base, 0,   0, dv(1'b1, 3'b000));
    push_cause("t3_cause", base, 0, 3'b100);
    push("t3_e255", base, 255, 0, dv(1'b1, 3'b000));
    push("t3_e256", base, 256, 0, dv(1'b1, 3'b001));
    push("t3_e288", base, 288, 0, dv(1'b0, 3'b111));
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    drain("t3", 400);

    // Level SW request held 10 cycles keeps the sequencer in ASSERT
    SW_RST_REQ = 1'b1;
    base = cyc;
    push("t3l_e0",   base, 0,   0, dv(1'b1, 3'b000));
    push("t3l_e9",   base, 9,   0, dv(1'b1, 3'b000));
    push("t3l_e264", base, 264, 0, dv(1'b1, 3'b000));
    push("t3l_e265", base, 265, 0, dv(1'b1, 3'b001));
    push("t3l_e297", base, 297, 0, dv(1'b0, 3'b111));
    repeat (10) @(negedge CLK);
    SW_RST_REQ = 1'b0;
    drain("t3l", 400);

    // SW request after RSTn_O[0] released but before RSTn_O[1]
    SW_RST_REQ = 1'b1;
    base = cyc;
    push("t4a_e0",   base, 0,   0, dv(1'b1, 3'b000));
    push("t4a_e256", base, 256, 0, dv(1'b1, 3'b001));
    push("t4a_e260", base, 260, 0, dv(1'b1, 3'b001));
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    repeat (260) @(negedge CLK);
    SW_RST_REQ = 1'b1;
    base = cyc;
    push("t4_e0",   base, 0,   0, dv(1'b1, 3'b000));
    push_cause("t4_cause", base, 0, 3'b100);
    push("t4_e255", base, 255, 0, dv(1'b1, 3'b000));
    push("t4_e256", base, 256, 0, dv(1'b1, 3'b001));
    push("t4_e272", base, 272, 0, dv(1'b1, 3'b011));
    push("t4_e288", base, 288, 0, dv(1'b0, 3'b111));
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    drain("t4", 400);

    // PORESETn asserted between clock edges in RUN
    @(posedge CLK);
    #2;
    PORESETn = 1'b0;
    #1;
    check("t5_async_dflt", observe(0), dv(1'b1, 3'b000));
    check("t5_async_fast", observe(1), fv(1'b1, 4'b0000));
`ifdef RESET_SEQ_CAUSE_EN
    check("t5_async_cause", observe(2), 8'h01);
`endif
    repeat (4) @(negedge CLK);
    PORESETn = 1'b1;
    base = cyc;
    push("t5_fast_e2", base, 2,   1, fv(1'b0, 4'b1111));
    push("t5_e256",    base, 256, 0, dv(1'b1, 3'b000));
    push("t5_e257",    base, 257, 0, dv(1'b1, 3'b001));
    push("t5_e289",    base, 289, 0, dv(1'b0, 3'b111));
    push_cause("t5_cause", base, 289, 3'b001);
    drain("t5", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
